// File: rtl/palette_loader.sv
// Palette download assembler: packs HPS download bytes into 24-bit entries,
// strobes the framebuffer palette port and fills a multi-bank shadow RAM.
module palette_loader #(
    parameter int unsigned ENTRIES = 256,
    parameter int unsigned AW      = 8,
    parameter int unsigned BPE     = 3,
    parameter int unsigned BANKS   = 2,
    parameter int unsigned BW      = 1,
    parameter int unsigned ORDER   = 0
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_en,
    input  logic          byte_wr,
    input  logic [7:0]    byte_in,
    input  logic [BW-1:0] bank_sel,
    output logic          pal_wr,
    output logic [AW-1:0] pal_addr,
    output logic [23:0]   pal_color,
    output logic [BW-1:0] pal_bank,
    input  logic [BW-1:0] rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [23:0]   rd_data,
    output logic [AW:0]   entries,
    output logic          load_done,
    output logic          overflow,
    output logic          partial
);

    localparam int unsigned Depth    = BANKS * ENTRIES;
    localparam logic [1:0]  LastByte = 2'(BPE - 1);
    localparam logic [AW:0] Full     = (AW + 1)'(ENTRIES);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [AW:0]   idx_q, idx_d;
    logic          en_seen_q, en_seen_d;
    logic          overflow_q, overflow_d;
    logic          partial_q, partial_d;
    logic          pal_wr_q, pal_wr_d;
    logic [AW-1:0] pal_addr_q, pal_addr_d;
    logic [23:0]   pal_color_q, pal_color_d;
    logic [BW-1:0] pal_bank_q, pal_bank_d;
    logic [23:0]   rd_data_q;

    logic [23:0]   mem [Depth];

    logic          last_byte;
    logic [7:0]    c2;
    logic [23:0]   asm_color;

    assign last_byte = (byte_cnt_q == LastByte);
    // With a 4-byte entry the third colour byte is already stored when the pad arrives.
    assign c2        = (BPE == 3) ? byte_in : b2_q;
    assign asm_color = (ORDER == 0) ? {b0_q, b1_q, c2} : {c2, b1_q, b0_q};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        idx_d       = idx_q;
        en_seen_d   = en_seen_q;
        overflow_d  = overflow_q;
        partial_d   = partial_q;
        pal_wr_d    = 1'b0;
        pal_addr_d  = pal_addr_q;
        pal_color_d = pal_color_q;
        pal_bank_d  = pal_bank_q;

        if (load_start) begin
            state_d    = StLoad;
            byte_cnt_d = 2'd0;
            idx_d      = '0;
            en_seen_d  = 1'b0;
            overflow_d = 1'b0;
            partial_d  = 1'b0;
            pal_bank_d = bank_sel;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StLoad: begin
                    if (load_en) begin
                        en_seen_d = 1'b1;
                        if (byte_wr) begin
                            case (byte_cnt_q)
                                2'd0:    b0_d = byte_in;
                                2'd1:    b1_d = byte_in;
                                2'd2:    b2_d = byte_in;
                                default: b2_d = b2_q;
                            endcase
                            if (last_byte) begin
                                byte_cnt_d = 2'd0;
                                if (idx_q < Full) begin
                                    pal_wr_d    = 1'b1;
                                    pal_addr_d  = idx_q[AW-1:0];
                                    pal_color_d = asm_color;
                                    idx_d       = idx_q + (AW + 1)'(1);
                                end else begin
                                    overflow_d = 1'b1;
                                end
                            end else begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                            end
                        end
                    end else if (en_seen_q) begin
                        // Segment ended; any half-built entry is thrown away.
                        state_d    = StDone;
                        byte_cnt_d = 2'd0;
                        if (byte_cnt_q != 2'd0) begin
                            partial_d = 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            byte_cnt_q  <= 2'd0;
            b0_q        <= 8'd0;
            b1_q        <= 8'd0;
            b2_q        <= 8'd0;
            idx_q       <= '0;
            en_seen_q   <= 1'b0;
            overflow_q  <= 1'b0;
            partial_q   <= 1'b0;
            pal_wr_q    <= 1'b0;
            pal_addr_q  <= '0;
            pal_color_q <= 24'd0;
            pal_bank_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            idx_q       <= idx_d;
            en_seen_q   <= en_seen_d;
            overflow_q  <= overflow_d;
            partial_q   <= partial_d;
            pal_wr_q    <= pal_wr_d;
            pal_addr_q  <= pal_addr_d;
            pal_color_q <= pal_color_d;
            pal_bank_q  <= pal_bank_d;
        end
    end

    // Shadow write lags the strobe cycle by one edge; the read port sees old data first.
    always_ff @(posedge clk_sys) begin
        if (pal_wr_q) begin
            mem[{pal_bank_q, pal_addr_q}] <= pal_color_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_data_q <= 24'd0;
        end else begin
            rd_data_q <= mem[{rd_bank, rd_addr}];
        end
    end

    assign pal_wr    = pal_wr_q;
    assign pal_addr  = pal_addr_q;
    assign pal_color = pal_color_q;
    assign pal_bank  = pal_bank_q;
    assign rd_data   = rd_data_q;
    assign entries   = idx_q;
    assign load_done = (state_q == StDone);
    assign overflow  = overflow_q;
    assign partial   = partial_q;

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: three configurations share one byte stream,
// each test checks the instance whose configuration it targets.
module tb_palette_loader;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       load_start, load_en, byte_wr;
    logic [7:0] byte_in;
    logic       bank_sel, rd_bank;
    logic [7:0] rd_addr;

    always #5 clk_sys = ~clk_sys;

    logic        d0_wr, d0_bank, d0_done, d0_ovf, d0_part;
    logic [7:0]  d0_addr;
    logic [23:0] d0_color, d0_rd;
    logic [8:0]  d0_ent;
    logic        d1_wr, d1_bank, d1_done, d1_ovf, d1_part;
    logic [7:0]  d1_addr;
    logic [23:0] d1_color, d1_rd;
    logic [8:0]  d1_ent;
    logic        d2_wr, d2_bank, d2_done, d2_ovf, d2_part;
    logic [1:0]  d2_addr;
    logic [23:0] d2_color, d2_rd;
    logic [2:0]  d2_ent;

    palette_loader dut0 (
        .clk_sys(clk_sys), .reset(reset), .load_start(load_start), .load_en(load_en),
        .byte_wr(byte_wr), .byte_in(byte_in), .bank_sel(bank_sel), .pal_wr(d0_wr),
        .pal_addr(d0_addr), .pal_color(d0_color), .pal_bank(d0_bank), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .rd_data(d0_rd), .entries(d0_ent), .load_done(d0_done),
        .overflow(d0_ovf), .partial(d0_part)
    );

    palette_loader #(.BPE(4), .ORDER(1)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .load_start(load_start), .load_en(load_en),
        .byte_wr(byte_wr), .byte_in(byte_in), .bank_sel(bank_sel), .pal_wr(d1_wr),
        .pal_addr(d1_addr), .pal_color(d1_color), .pal_bank(d1_bank), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .rd_data(d1_rd), .entries(d1_ent), .load_done(d1_done),
        .overflow(d1_ovf), .partial(d1_part)
    );

    palette_loader #(.ENTRIES(4), .AW(2)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .load_start(load_start), .load_en(load_en),
        .byte_wr(byte_wr), .byte_in(byte_in), .bank_sel(bank_sel), .pal_wr(d2_wr),
        .pal_addr(d2_addr), .pal_color(d2_color), .pal_bank(d2_bank), .rd_bank(rd_bank),
        .rd_addr(rd_addr[1:0]), .rd_data(d2_rd), .entries(d2_ent), .load_done(d2_done),
        .overflow(d2_ovf), .partial(d2_part)
    );

    int total  = 0;
    int passed = 0;
    int wr0    = 0;
    int wr1    = 0;
    int wr2    = 0;

    typedef struct {
        logic        ls, en, wr;
        logic [7:0]  din;
        logic        exp_wr;
        logic [7:0]  exp_addr;
        logic [23:0] exp_color;
        logic [8:0]  exp_ent;
        logic        exp_done;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One clock: drive on the falling edge, sample just after the rising edge.
    task automatic cyc(input logic ls, input logic en, input logic wr, input logic [7:0] din);
        @(negedge clk_sys);
        load_start = ls;
        load_en    = en;
        byte_wr    = wr;
        byte_in    = din;
        @(posedge clk_sys);
        #1;
        wr0 += int'(d0_wr);
        wr1 += int'(d1_wr);
        wr2 += int'(d2_wr);
    endtask

    task automatic rd(input logic b, input logic [7:0] a);
        rd_bank = b;
        rd_addr = a;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 24'h000000, 9'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 24'h000000, 9'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 24'h000000, 9'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h00, 24'h112233, 9'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 24'h000000, 9'd1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 24'h000000, 9'd1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 8'h01, 24'h445566, 9'd2, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 24'h000000, 9'd2, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 24'h000000, 9'd2, 1'b0};

        reset      = 1'b0;
        load_start = 1'b0;
        load_en    = 1'b0;
        byte_wr    = 1'b0;
        byte_in    = 8'h00;
        bank_sel   = 1'b0;
        rd_bank    = 1'b0;
        rd_addr    = 8'h00;
        #2 reset   = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_wr", 32'(d0_wr), 0);
        chk("rst_addr", 32'(d0_addr), 0);
        chk("rst_color", 32'(d0_color), 0);
        chk("rst_bank", 32'(d0_bank), 0);
        chk("rst_rd", 32'(d0_rd), 0);
        chk("rst_ent", 32'(d0_ent), 0);
        chk("rst_done", 32'(d0_done), 0);
        chk("rst_ovf", 32'(d0_ovf), 0);
        chk("rst_part", 32'(d0_part), 0);
        @(negedge clk_sys);
        reset = 1'b0;

        // Two RGB entries, back-to-back bytes.
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].ls, vecs[i].en, vecs[i].wr, vecs[i].din);
            chk($sformatf("t1_wr[%0d]", i), 32'(d0_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("t1_ent[%0d]", i), 32'(d0_ent), 32'(vecs[i].exp_ent));
            chk($sformatf("t1_done[%0d]", i), 32'(d0_done), 32'(vecs[i].exp_done));
            if (vecs[i].exp_wr) begin
                chk($sformatf("t1_addr[%0d]", i), 32'(d0_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("t1_color[%0d]", i), 32'(d0_color), 32'(vecs[i].exp_color));
            end
        end
        chk("t1_part", 32'(d0_part), 0);
        rd(1'b0, 8'd1);
        chk("t1_rd1", 32'(d0_rd), 32'h445566);
        rd(1'b0, 8'd0);
        chk("t1_rd0", 32'(d0_rd), 32'h112233);

        // BGR order with a pad byte.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        wr1 = 0;
        chk("t2_ent0", 32'(d1_ent), 0);
        cyc(1'b0, 1'b1, 1'b1, 8'hAA);
        cyc(1'b0, 1'b1, 1'b1, 8'hBB);
        cyc(1'b0, 1'b1, 1'b1, 8'hCC);
        chk("t2_wr_early", 32'(d1_wr), 0);
        cyc(1'b0, 1'b1, 1'b1, 8'hDD);
        chk("t2_wr", 32'(d1_wr), 1);
        chk("t2_color", 32'(d1_color), 32'hCCBBAA);
        chk("t2_addr", 32'(d1_addr), 0);
        chk("t2_ent", 32'(d1_ent), 1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t2_done", 32'(d1_done), 1);
        chk("t2_part", 32'(d1_part), 0);
        chk("t2_wrcnt", 32'(wr1), 1);
        chk("t2_rgb_part", 32'(d0_part), 1);
        rd(1'b0, 8'd0);
        chk("t2_rd", 32'(d1_rd), 32'hCCBBAA);

        // Second bank.
        bank_sel = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        bank_sel = 1'b0;
        chk("t3_bank", 32'(d0_bank), 1);
        cyc(1'b0, 1'b1, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 1'b1, 8'h03);
        chk("t3_wr", 32'(d0_wr), 1);
        chk("t3_color", 32'(d0_color), 32'h010203);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t3_pad_part", 32'(d1_part), 1);
        rd(1'b1, 8'd0);
        chk("t3_rd_b1", 32'(d0_rd), 32'h010203);
        rd(1'b0, 8'd0);
        chk("t3_rd_b0", 32'(d0_rd), 32'hAABBCC);

        // Five entries into a four-entry palette.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        wr0 = 0;
        wr2 = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(i));
        end
        chk("t4_wrcnt", 32'(wr2), 4);
        chk("t4_ovf", 32'(d2_ovf), 1);
        chk("t4_ent", 32'(d2_ent), 4);
        chk("t4_big_wrcnt", 32'(wr0), 5);
        chk("t4_big_ent", 32'(d0_ent), 5);
        chk("t4_big_ovf", 32'(d0_ovf), 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t4_done", 32'(d2_done), 1);
        rd(1'b0, 8'd3);
        chk("t4_rd3", 32'(d2_rd), 32'h090A0B);
        rd(1'b0, 8'd0);
        chk("t4_rd0", 32'(d2_rd), 32'h000102);
        rd(1'b0, 8'd4);
        chk("t4_big_rd4", 32'(d0_rd), 32'h0C0D0E);

        // Partial entry, then restart clears the flags.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        wr0 = 0;
        chk("t5_ovf_clr", 32'(d2_ovf), 0);
        chk("t5_ent_clr", 32'(d2_ent), 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(8'h50 + i));
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t5_wrcnt", 32'(wr0), 2);
        chk("t5_part", 32'(d0_part), 1);
        chk("t5_done", 32'(d0_done), 1);
        chk("t5_ent", 32'(d0_ent), 2);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t5_part_clr", 32'(d0_part), 0);
        chk("t5_ent_clr0", 32'(d0_ent), 0);
        cyc(1'b0, 1'b1, 1'b1, 8'h60);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t5_abort_part", 32'(d0_part), 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t5_no_done", 32'(d0_done), 0);

        // Asynchronous reset in the middle of an entry.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h01);
        #1 reset = 1'b1;
        #1;
        chk("t6_wr", 32'(d0_wr), 0);
        chk("t6_ent", 32'(d0_ent), 0);
        chk("t6_color", 32'(d0_color), 0);
        chk("t6_rd", 32'(d0_rd), 0);
        chk("t6_bank", 32'(d0_bank), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        wr0   = 0;
        cyc(1'b0, 1'b1, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 1'b1, 8'h03);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_no_wr", 32'(wr0), 0);
        chk("t6_no_done", 32'(d0_done), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b1, 1'b1, 8'h88);
        cyc(1'b0, 1'b1, 1'b1, 8'h99);
        chk("t6_new_wr", 32'(d0_wr), 1);
        chk("t6_new_addr", 32'(d0_addr), 0);
        chk("t6_new_color", 32'(d0_color), 32'h778899);
        chk("t6_new_ent", 32'(d0_ent), 1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_new_done", 32'(d0_done), 1);
        rd(1'b0, 8'd0);
        chk("t6_new_rd", 32'(d0_rd), 32'h778899);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
